// File: rtl/wb_bus_arbiter.sv
// Round-robin WISHBONE bus arbiter. A grant is held for a whole CYC cycle,
// and an optional watchdog revokes a grant that is held for too long.
module wb_bus_arbiter #(
    parameter int N_MASTERS        = 2,
    parameter int N_BITS_MASTER_ID = $clog2(N_MASTERS),
    parameter int MAX_HOLD         = 256,
    parameter int N_BITS_HOLD      = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_MASTERS-1:0]        cyc_i,
    output logic [N_MASTERS-1:0]        gnt_o,
    output logic [N_BITS_MASTER_ID-1:0] gnt_id_o,
    output logic                        bus_busy_o,
    output logic                        timeout_o,
    output logic [N_MASTERS-1:0]        blocked_o
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam bit                        WDOG_EN    = (MAX_HOLD > 0);
    localparam logic [N_BITS_MASTER_ID:0] N_EXT      = (N_BITS_MASTER_ID + 1)'(N_MASTERS);
    localparam logic [N_BITS_HOLD-1:0]    HOLD_LIMIT = WDOG_EN ? N_BITS_HOLD'(MAX_HOLD - 1) : '0;
    localparam logic [N_BITS_HOLD-1:0]    HOLD_SAT   = N_BITS_HOLD'(MAX_HOLD);

    state_t                        state_reg, state_next;
    logic [N_MASTERS-1:0]          gnt_reg, gnt_next;
    logic [N_MASTERS-1:0]          blocked_reg, blocked_next, blocked_set;
    logic [N_BITS_MASTER_ID-1:0]   gnt_id_reg, gnt_id_next;
    logic [N_BITS_MASTER_ID-1:0]   ptr_reg, ptr_next;
    logic [N_BITS_HOLD-1:0]        hold_cnt_reg, hold_cnt_next;
    logic                          timeout_reg, timeout_next;
    logic                          busy_reg, busy_next;

    logic [N_MASTERS-1:0]          eligible;
    logic [N_BITS_MASTER_ID-1:0]   cand_id [N_MASTERS];
    logic [N_BITS_MASTER_ID-1:0]   sel_id;
    logic                          sel_valid;
    logic [N_BITS_MASTER_ID-1:0]   owner_inc;

    // Modulo-N addition; both operands are below N so one subtraction suffices.
    function automatic logic [N_BITS_MASTER_ID-1:0] wrap_add(
        input logic [N_BITS_MASTER_ID-1:0] base,
        input logic [N_BITS_MASTER_ID:0]   off
    );
        logic [N_BITS_MASTER_ID:0] sum;
        sum = {1'b0, base} + off;
        if (sum >= N_EXT) begin
            sum = sum - N_EXT;
        end
        return sum[N_BITS_MASTER_ID-1:0];
    endfunction

    assign eligible  = cyc_i & ~blocked_reg;
    assign owner_inc = wrap_add(gnt_id_reg, (N_BITS_MASTER_ID + 1)'(1));

    generate
        for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_cand
            assign cand_id[gi] = wrap_add(ptr_reg, (N_BITS_MASTER_ID + 1)'(gi));
        end
    endgenerate

    // Scan from the farthest offset down so the candidate nearest ptr wins.
    always_comb begin
        sel_valid = 1'b0;
        sel_id    = ptr_reg;
        for (int k = N_MASTERS - 1; k >= 0; k--) begin
            if (eligible[cand_id[k]]) begin
                sel_valid = 1'b1;
                sel_id    = cand_id[k];
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        gnt_next      = gnt_reg;
        gnt_id_next   = gnt_id_reg;
        ptr_next      = ptr_reg;
        hold_cnt_next = hold_cnt_reg;
        timeout_next  = 1'b0;
        blocked_set   = '0;
        case (state_reg)
            IDLE: begin
                if (sel_valid) begin
                    gnt_next      = N_MASTERS'(1) << sel_id;
                    gnt_id_next   = sel_id;
                    hold_cnt_next = '0;
                    state_next    = BUSY;
                end
            end
            BUSY: begin
                if (!cyc_i[gnt_id_reg]) begin
                    gnt_next   = '0;
                    ptr_next   = owner_inc;
                    state_next = IDLE;
                end else if (WDOG_EN && (hold_cnt_reg == HOLD_LIMIT)) begin
                    gnt_next     = '0;
                    timeout_next = 1'b1;
                    blocked_set  = gnt_reg;
                    ptr_next     = owner_inc;
                    state_next   = IDLE;
                end else if (hold_cnt_reg != HOLD_SAT) begin
                    hold_cnt_next = hold_cnt_reg + 1'b1;
                end
            end
            default: begin
                gnt_next   = '0;
                state_next = IDLE;
            end
        endcase
        // A block only survives while the master keeps CYC asserted.
        blocked_next = (blocked_reg & cyc_i) | blocked_set;
        busy_next    = |gnt_next;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= IDLE;
            gnt_reg      <= '0;
            gnt_id_reg   <= '0;
            ptr_reg      <= '0;
            hold_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
            blocked_reg  <= '0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            gnt_reg      <= gnt_next;
            gnt_id_reg   <= gnt_id_next;
            ptr_reg      <= ptr_next;
            hold_cnt_reg <= hold_cnt_next;
            timeout_reg  <= timeout_next;
            blocked_reg  <= blocked_next;
            busy_reg     <= busy_next;
        end
    end

    assign gnt_o      = gnt_reg;
    assign gnt_id_o   = gnt_id_reg;
    assign bus_busy_o = busy_reg;
    assign timeout_o  = timeout_reg;
    assign blocked_o  = blocked_reg;

endmodule

// File: doc/wb_bus_arbiter.md
Name: wb_bus_arbiter

Overview:
- Round-robin arbiter for the shared WISHBONE bus between the node and the NIC's noc2wb master port.
- One of its gnt_o bits drives the NIC gnt_wb_i input. Other bits grant node-side masters, e.g. a CPU or DMA.
- Grant is held for a whole CYC cycle, so bursts are never split. An optional watchdog revokes a grant that is held too long and blocks that master until it drops CYC.

Parameters:
- N_MASTERS, 2, number of requesting masters (2..8).
- N_BITS_MASTER_ID, clog2(N_MASTERS), width of the owner index.
- MAX_HOLD, 256, maximum cycles one grant may be held; 0 disables the watchdog.
- N_BITS_HOLD, clog2(MAX_HOLD+1), width of the hold counter.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous, active-low reset (0 = reset), sampled on the rising clk edge.
- cyc_i  in  N_MASTERS  CYC of each master; bit i = request of master i.
- gnt_o  out  N_MASTERS  registered one-hot grant; all-zero when the bus is idle.
- gnt_id_o  out  N_BITS_MASTER_ID  index of current owner; valid only when bus_busy_o=1.
- bus_busy_o  out  1  1 while any gnt_o bit is set.
- timeout_o  out  1  one-cycle pulse when the watchdog revokes a grant.
- blocked_o  out  N_MASTERS  masters currently excluded after a timeout.

Behaviour:
- Reset (rst=0 at an edge): state=IDLE, gnt_o=0, gnt_id_o=0, bus_busy_o=0, timeout_o=0, blocked_o=0, rr pointer=0, hold counter=0.
- Eligible mask: eligible = cyc_i & ~blocked_o.
- Selection: first eligible index scanning ptr, ptr+1, … N_MASTERS-1, 0, … ptr-1, with wrap-around.
- FSM has two states, IDLE and BUSY.
- IDLE:
  - If eligible != 0: at the next edge, gnt_o=onehot(sel), gnt_id_o=sel, state=BUSY, counter=0.
  - Otherwise stay IDLE.
  - Grant latency is 1 cycle from cyc_i rising, when no other owner holds the bus.
- BUSY, normal release:
  - Condition: cyc_i[gnt_id_o]=0.
  - At the next edge: gnt_o=0, ptr=(gnt_id_o+1) mod N_MASTERS, state=IDLE.
  - The next grant can appear at the earliest 2 edges after the owner drops CYC (1 turnaround cycle). No back-to-back handover, so the bus can settle.
- BUSY, hold: if cyc_i[owner]=1, the counter increments by 1 per cycle and saturates at MAX_HOLD. Requests from other masters are ignored.
- BUSY, watchdog (MAX_HOLD>0):
  - Condition: cyc_i[owner]=1 and counter==MAX_HOLD-1.
  - At the next edge: gnt_o=0, timeout_o=1 for exactly 1 cycle, blocked_o[owner]=1, ptr=owner+1, state=IDLE.
  - The grant was held exactly MAX_HOLD cycles.
- Blocking:
  - blocked_o[i] clears at the edge after a cycle with cyc_i[i]=0.
  - A blocked master must deassert CYC for at least 1 cycle before it can be granted again.
- Simultaneous events:
  - Owner drops CYC in the same cycle the counter hits MAX_HOLD-1: this is a normal release; no timeout and no block.
  - blocked_o set and clear never coincide: the set applies only to an owner whose cyc_i=1.
- Pointer: updated only on release or timeout, never while IDLE. This gives fairness: every continuously requesting, unblocked master is granted within N_MASTERS-1 other grants.
- Invariants:
  - gnt_o is always one-hot or zero.
  - bus_busy_o == |gnt_o.
  - gnt_o never changes during BUSY except on release or timeout.
- Reset asserted mid-grant: gnt_o drops at that edge; the master sees its grant lost with no timeout pulse.
- Glitch-free: all outputs are registered; there is no combinational path from cyc_i to gnt_o.

Test Plan:
1. Reset then single request: rst=0 for 2 cycles, then cyc_i=2'b01 → gnt_o=01 one edge later, gnt_id_o=0, bus_busy_o=1.
2. Round robin with N=2 and cyc_i=11 held: each master drops CYC after 4 cycles and re-requests 1 cycle later → grants alternate 01, 10, 01, with one idle cycle between grants and no master granted twice in a row.
3. Burst hold: master 1 owns the bus for 20 cycles while cyc_i[0]=1 → gnt_o stays 10 the entire time; gnt_o=01 exactly 2 edges after cyc_i[1] falls.
4. Watchdog with MAX_HOLD=8, master 0 holding CYC forever:
   - gnt_o=01 for exactly 8 cycles, then gnt_o=00 and timeout_o=1 for 1 cycle; blocked_o=01.
   - Master 1 requesting is granted at the next edge.
   - Master 0 is not re-granted until it drops CYC for at least 1 cycle.
5. Coincident release and timeout with MAX_HOLD=8: owner drops CYC in its 8th granted cycle → timeout_o stays 0 and blocked_o stays 00.
6. Mid-grant reset: rst=0 during BUSY → gnt_o=0, bus_busy_o=0, ptr=0 at that edge. After reset release with cyc_i=11, master 0 is granted first.
